// File: rtl/wrr_grant_controller.sv
// Weighted round-robin grant controller.
//
// Shares one resource among N requesters. The owner keeps the grant until it
// signals done, drops its request, or exceeds MAX_HOLD cycles. Each requester
// has a programmable weight that sets how many back-to-back grants it may take
// before the round-robin pointer moves past it.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous, active-high reset
//   req        - per-requester request level
//   done       - owner finished its transfer (ignored while idle)
//   cfg_we     - weight write strobe
//   cfg_idx    - requester index for the weight write (>= N ignored)
//   cfg_weight - weight value (0 behaves as 1)
//   grant      - registered one-hot grant, zero when idle
//   grant_id   - binary index of the owner, valid when busy
//   busy       - a grant is active
//   timeout    - one-cycle pulse after a forced release
module wrr_grant_controller #(
    parameter int unsigned N        = 4,
    parameter int unsigned WW       = 4,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 done,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_idx,
    input  logic [WW-1:0]        cfg_weight,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned IW          = $clog2(N);
    localparam int unsigned HW          = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned HoldLastInt = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HW-1:0] HoldLast  = HoldLastInt[HW-1:0];
    localparam logic          HoldEn    = (MAX_HOLD != 0);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   credit_q, credit_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            timeout_q, timeout_d;
    logic [WW-1:0]   weight_q [N];

    logic [IW-1:0]   adv_ptr;
    logic [IW-1:0]   arb_ptr;
    logic [IW-1:0]   arb_idx;
    logic            arb_found;
    logic            owner_req;
    logic            hold_hit;
    logic            release_ev;

    // Credit left after taking one grant; a zero weight counts as one grant.
    function automatic logic [WW-1:0] reload_credit(input logic [WW-1:0] w);
        return (w == '0) ? '0 : w - 1'b1;
    endfunction

    // Pointer just past the current owner, wrapping at N.
    assign adv_ptr = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + 1'b1;

    // While busy the search must already start past the owner so a handover
    // happens in the same edge as the release.
    assign arb_ptr = (state_q == StBusy) ? adv_ptr : ptr_q;

    // Circular first-set search starting at arb_ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned   j;
            logic [IW-1:0] j_idx;
            j = int'(arb_ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            j_idx = IW'(j);
            if (!arb_found && req[j_idx]) begin
                arb_found = 1'b1;
                arb_idx   = j_idx;
            end
        end
    end

    assign owner_req  = req[grant_id_q];
    // A coincident done wins over the timeout, so no pulse in that case.
    assign hold_hit   = HoldEn && (hold_cnt_q == HoldLast) && !done;
    assign release_ev = done || !owner_req || hold_hit;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        credit_d   = credit_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    state_d    = StBusy;
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << arb_idx;
                    grant_id_d = arb_idx;
                    credit_d   = reload_credit(weight_q[arb_idx]);
                    hold_cnt_d = '0;
                end
            end
            StBusy: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                timeout_d  = hold_hit;
                if (release_ev) begin
                    if (owner_req && (credit_q != '0) && !hold_hit) begin
                        // Owner spends one credit and keeps the grant.
                        credit_d   = credit_q - 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        // Timeout also lands here: remaining credit is forfeited.
                        ptr_d      = adv_ptr;
                        hold_cnt_d = '0;
                        if (arb_found) begin
                            grant_d    = {{(N-1){1'b0}}, 1'b1} << arb_idx;
                            grant_id_d = arb_idx;
                            credit_d   = reload_credit(weight_q[arb_idx]);
                        end else begin
                            state_d    = StIdle;
                            grant_d    = '0;
                            grant_id_d = '0;
                            credit_d   = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            credit_q   <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            credit_q   <= credit_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Decoding per entry drops out-of-range indices without a separate compare.
    // A reload in the same edge reads weight_q before this write lands.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                weight_q[i] <= WW'(1);
            end else if (cfg_we && (cfg_idx == IW'(i))) begin
                weight_q[i] <= cfg_weight;
            end
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q == StBusy);
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_wrr_grant_controller.sv
// Directed testbench for wrr_grant_controller (N=4, WW=4, MAX_HOLD=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_wrr_grant_controller;

    localparam int unsigned N        = 4;
    localparam int unsigned WW       = 4;
    localparam int unsigned MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic         cfg_we;
    logic [1:0]   cfg_idx;
    logic [WW-1:0] cfg_weight;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    int checks = 0;
    int passed = 0;

    wrr_grant_controller #(
        .N        (N),
        .WW       (WW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_weight (cfg_weight),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        done       = 1'b0;
        cfg_we     = 1'b0;
        cfg_idx    = '0;
        cfg_weight = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic write_weight(input logic [1:0] idx, input logic [WW-1:0] w);
        cfg_we     = 1'b1;
        cfg_idx    = idx;
        cfg_weight = w;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant);
        else passed++;
        checks++;
        if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        checks++;
        if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout);
        else passed++;
        // done while idle must be ignored
        done = 1'b1;
        step();
        step();
        done = 1'b0;
        checks++;
        if (busy !== 1'b0 || grant !== 4'b0000)
            $display("FAIL idle_done: got busy=%b grant=%b want busy=0 grant=0000", busy, grant);
        else passed++;
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g  [5];
        logic [1:0]   exp_id [5];
        exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (grant !== exp_g[g] || busy !== 1'b1)
                    $display("FAIL fair_grant g=%0d c=%0d: got %b busy=%b want %b busy=1",
                             g, c, grant, busy, exp_g[g]);
                else passed++;
                if (c == 0) begin
                    checks++;
                    if (grant_id !== exp_id[g])
                        $display("FAIL fair_id g=%0d: got %0d want %0d", g, grant_id, exp_id[g]);
                    else passed++;
                end
                done = (c == 2);
                step();
            end
        end
        done = 1'b0;
    endtask

    task automatic test_weighting();
        logic [N-1:0] exp_g [8];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                  4'b0001, 4'b0001, 4'b0001, 4'b0010};
        do_reset();
        write_weight(2'd0, 4'd3);
        req  = 4'b0011;
        done = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (grant !== exp_g[k])
                $display("FAIL weight_seq k=%0d: got %b want %b", k, grant, exp_g[k]);
            else passed++;
            step();
        end
        done = 1'b0;
    endtask

    task automatic test_weight_zero();
        logic [N-1:0] exp_g [4];
        exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        do_reset();
        write_weight(2'd2, 4'd0);
        req  = 4'b0101;
        done = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (grant !== exp_g[k])
                $display("FAIL weight_zero k=%0d: got %b want %b", k, grant, exp_g[k]);
            else passed++;
            step();
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        write_weight(2'd0, 4'd3);
        req  = 4'b0101;
        done = 1'b0;
        step();
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (grant !== 4'b0001 || timeout !== 1'b0)
                $display("FAIL to_hold0 c=%0d: got grant=%b timeout=%b want 0001/0",
                         c, grant, timeout);
            else passed++;
            step();
        end
        // Weight 3 credit is forfeited: grant moves on instead of staying.
        checks++;
        if (grant !== 4'b0100 || timeout !== 1'b1)
            $display("FAIL to_release: got grant=%b timeout=%b want 0100/1", grant, timeout);
        else passed++;
        step();
        checks++;
        if (grant !== 4'b0100 || timeout !== 1'b0)
            $display("FAIL to_pulse_end: got grant=%b timeout=%b want 0100/0", grant, timeout);
        else passed++;
        step();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (grant !== 4'b0100 || timeout !== 1'b0)
                $display("FAIL to_hold2 c=%0d: got grant=%b timeout=%b want 0100/0",
                         c, grant, timeout);
            else passed++;
            step();
        end
        checks++;
        if (grant !== 4'b0001 || timeout !== 1'b1)
            $display("FAIL to_second: got grant=%b timeout=%b want 0001/1", grant, timeout);
        else passed++;
    endtask

    task automatic test_done_timeout();
        do_reset();
        req  = 4'b0001;
        done = 1'b0;
        step();
        for (int c = 0; c < 7; c++) step();
        // hold count is now at its last value; done coincides with the timeout
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (timeout !== 1'b0 || grant !== 4'b0001 || busy !== 1'b1)
            $display("FAIL done_to_coincide: got timeout=%b grant=%b busy=%b want 0/0001/1",
                     timeout, grant, busy);
        else passed++;
        // Hold timer restarted on the regrant: next forced release 8 cycles later.
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (timeout !== 1'b0)
                $display("FAIL done_to_restart c=%0d: got timeout=%b want 0", c, timeout);
            else passed++;
            step();
        end
        checks++;
        if (timeout !== 1'b1 || grant !== 4'b0001)
            $display("FAIL done_to_next: got timeout=%b grant=%b want 1/0001", timeout, grant);
        else passed++;
    endtask

    task automatic test_dropout();
        do_reset();
        req = 4'b0010;
        step();
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1 || busy !== 1'b1)
            $display("FAIL drop_grant: got grant=%b id=%0d busy=%b want 0010/1/1",
                     grant, grant_id, busy);
        else passed++;
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0)
            $display("FAIL drop_idle: got grant=%b busy=%b want 0000/0", grant, busy);
        else passed++;
        // Pointer now 2: requester 3 must beat requester 0.
        req = 4'b1001;
        step();
        checks++;
        if (grant !== 4'b1000 || grant_id !== 2'd3 || busy !== 1'b1)
            $display("FAIL drop_ptr: got grant=%b id=%0d busy=%b want 1000/3/1",
                     grant, grant_id, busy);
        else passed++;
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        write_weight(2'd0, 4'd2);
        req  = 4'b1111;
        done = 1'b1;
        step();  // 0001, credit 1
        step();  // 0001, credit 0
        step();  // 0010
        step();  // 0100, pointer 2
        done = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0 || timeout !== 1'b0)
            $display("FAIL rst_mid: got grant=%b busy=%b id=%0d to=%b want 0000/0/0/0",
                     grant, busy, grant_id, timeout);
        else passed++;
        rst  = 1'b0;
        done = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001)
            $display("FAIL rst_ptr: got grant=%b want 0001", grant);
        else passed++;
        step();
        checks++;
        if (grant !== 4'b0010)
            $display("FAIL rst_weight: got grant=%b want 0010", grant);
        else passed++;
        done = 1'b0;
        req  = 4'b0000;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        done       = 1'b0;
        cfg_we     = 1'b0;
        cfg_idx    = '0;
        cfg_weight = '0;
        test_reset();
        test_fairness();
        test_weighting();
        test_weight_zero();
        test_timeout();
        test_done_timeout();
        test_dropout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
